// File: rtl/rowidct_sched.sv
// Row-IDCT scheduler: loads a 64-coefficient block, issues its 8 rows to an external datapath,
// writes each result row back in place and drains the block. Option: ROWIDCT_SCHED_ZERO_SKIP_EN.
module rowidct_sched #(
  parameter int unsigned ROW_LAT = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [31:0]  in_data,
  output logic [255:0] row_x,
  input  logic [255:0] row_y,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [31:0]  out_data,
  output logic         out_last,
  output logic         busy
);

  typedef enum logic [1:0] {StLoad, StIssue, StWait, StDrain} state_e;

  localparam logic [3:0] WLast = 4'(ROW_LAT - 1);
  // Source element for datapath slots x7..x0 (packed MSB first).
  localparam logic [23:0] SlotSrc = {3'd3, 3'd5, 3'd7, 3'd1, 3'd2, 3'd6, 3'd4, 3'd0};

  state_e         state_q, state_d;
  logic [2:0]     r_q, r_d;
  logic [5:0]     n_q, n_d;
  logic [3:0]     w_q, w_d;
  logic [255:0]   row_x_q, row_x_d;
  logic           live_q;
  logic [31:0]    buf_q [64];

  logic [31:0]    slot [8];
  logic [255:0]   row_x_issue;
  logic           buf_we;
  logic           row_we;
  logic           row_done;
  logic [31:0]    row_wdata [8];
`ifdef ROWIDCT_SCHED_ZERO_SKIP_EN
  logic           row_zero;
`endif

  always_comb begin
    row_x_issue = '0;
    for (int k = 0; k < 8; k++) begin
      slot[k] = buf_q[{r_q, SlotSrc[3*k +: 3]}];
      row_x_issue[32*k +: 32] = slot[k];
    end
  end

`ifdef ROWIDCT_SCHED_ZERO_SKIP_EN
  assign row_zero = ~|row_x_issue[255:32];
`endif

  always_comb begin
    state_d  = state_q;
    r_d      = r_q;
    n_d      = n_q;
    w_d      = w_q;
    row_x_d  = row_x_q;
    buf_we   = 1'b0;
    row_we   = 1'b0;
    row_done = 1'b0;
    for (int k = 0; k < 8; k++) begin
      row_wdata[k] = row_y[32*k +: 32];
    end

    in_ready  = (state_q == StLoad) && live_q;
    out_valid = (state_q == StDrain);
    out_data  = out_valid ? buf_q[n_q] : '0;
    out_last  = out_valid && (n_q == 6'd63);
    busy      = (state_q != StLoad) || (n_q != 6'd0);

    unique case (state_q)
      StLoad: begin
        if (in_valid && in_ready) begin
          buf_we = 1'b1;
          n_d    = n_q + 6'd1;
          if (n_q == 6'd63) begin
            state_d = StIssue;
            r_d     = 3'd0;
          end
        end
      end
      StIssue: begin
        row_x_d = row_x_issue;
`ifdef ROWIDCT_SCHED_ZERO_SKIP_EN
        if (row_zero) begin
          // DC-only row: the datapath result is x0 scaled by 8 in every element.
          row_we   = 1'b1;
          row_done = 1'b1;
          for (int k = 0; k < 8; k++) begin
            row_wdata[k] = slot[0] << 3;
          end
        end else begin
          state_d = StWait;
          w_d     = 4'd0;
        end
`else
        state_d = StWait;
        w_d     = 4'd0;
`endif
      end
      StWait: begin
        if (w_q == WLast) begin
          row_we   = 1'b1;
          row_done = 1'b1;
        end else begin
          w_d = w_q + 4'd1;
        end
      end
      StDrain: begin
        if (out_ready) begin
          n_d = n_q + 6'd1;
          if (n_q == 6'd63) begin
            state_d = StLoad;
          end
        end
      end
      default: state_d = StLoad;
    endcase

    if (row_done) begin
      if (r_q == 3'd7) begin
        state_d = StDrain;
        n_d     = 6'd0;
      end else begin
        state_d = StIssue;
        r_d     = r_q + 3'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StLoad;
      r_q     <= '0;
      n_q     <= '0;
      w_q     <= '0;
      row_x_q <= '0;
      live_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      n_q     <= n_d;
      w_q     <= w_d;
      row_x_q <= row_x_d;
      live_q  <= 1'b1;
    end
  end

  // Block storage is deliberately not reset; an abandoned block is simply overwritten.
  always_ff @(posedge clk) begin
    if (buf_we) begin
      buf_q[n_q] <= in_data;
    end
    if (row_we) begin
      for (int k = 0; k < 8; k++) begin
        buf_q[{r_q, 3'(k)}] <= row_wdata[k];
      end
    end
  end

  assign row_x = row_x_q;

endmodule

// File: tb/tb_rowidct_sched.sv
// Scoreboard bench for rowidct_sched: two instances (ROW_LAT 1 and 3) with a delayed datapath model.
module tb_rowidct_sched;

  typedef logic [31:0] blk_t [64];

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid  [2];
  logic         out_ready [2];
  logic [31:0]  in_data;
  logic         in_ready  [2];
  logic         out_valid [2];
  logic         out_last  [2];
  logic         busy      [2];
  logic [31:0]  out_data  [2];
  logic [255:0] row_x     [2];
  logic [255:0] row_y     [2];

  int           checks = 0;
  int           errors = 0;
  logic [31:0]  exp_q [$];
  int           active = -1;
  int           beats_seen = 0;

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Datapath stand-in: equals x0*8 in every element whenever x1..x7 are all zero.
  function automatic logic [255:0] dp(input logic [255:0] x);
    logic [255:0] y;
    logic [31:0]  acc;
    y = '0;
    for (int k = 0; k < 8; k++) begin
      acc = x[31:0] << 3;
      for (int j = 1; j < 8; j++) begin
        acc = acc + x[32*j +: 32] * 32'(j + k + 1);
      end
      y[32*k +: 32] = acc;
    end
    return y;
  endfunction

  function automatic logic [255:0] gather(input blk_t blk, input int r);
    int           src [8] = '{0, 4, 6, 2, 1, 7, 5, 3};
    logic [255:0] x;
    x = '0;
    for (int k = 0; k < 8; k++) begin
      x[32*k +: 32] = blk[8*r + src[k]];
    end
    return x;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int unsigned Lat = (g == 0) ? 1 : 3;

    rowidct_sched #(.ROW_LAT(Lat)) u_dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid[g]),
      .in_ready  (in_ready[g]),
      .in_data   (in_data),
      .row_x     (row_x[g]),
      .row_y     (row_y[g]),
      .out_valid (out_valid[g]),
      .out_ready (out_ready[g]),
      .out_data  (out_data[g]),
      .out_last  (out_last[g]),
      .busy      (busy[g])
    );

    int           age = 0;
    logic [255:0] prev = '0;
    logic         held_v = 1'b0;
    logic [31:0]  held_d = '0;

    always @(negedge clk) begin
      // row_y is garbage until Lat cycles after row_x last changed.
      if (row_x[g] != prev) age = 1;
      else if (age < 1000) age++;
      prev = row_x[g];
      row_y[g] = (age >= int'(Lat)) ? dp(row_x[g]) : {8{32'hDEAD_BEEF}};

      if (active == g && reset) begin
        if (out_valid[g]) begin
          if (held_v) check("hold", out_data[g], held_d);
          held_v = !out_ready[g];
          held_d = out_data[g];
          if (out_ready[g]) begin
            if (exp_q.size() == 0) check("sb_underflow", 32'(exp_q.size()), 32'd1);
            else check("data", out_data[g], exp_q.pop_front());
            check("last", out_last[g], beats_seen == 63);
            beats_seen++;
          end
        end else begin
          held_v = 1'b0;
        end
      end
    end
  end

  task automatic run_block(input int g, input blk_t blk, input bit toggle, input bit stuff,
                           input int abort_at);
    logic [255:0] x, x0;
    int           lat_row, exp_lat, lat, cyc;
    bit           got;
    lat_row = (g == 0) ? 1 : 3;
    exp_lat = 0;
    x0 = '0;
    exp_q.delete();
    for (int r = 0; r < 8; r++) begin
      x = gather(blk, r);
      if (r == 0) x0 = x;
      for (int k = 0; k < 8; k++) exp_q.push_back(dp(x) >> (32 * k));
`ifdef ROWIDCT_SCHED_ZERO_SKIP_EN
      exp_lat += (x[255:32] == '0) ? 1 : 1 + lat_row;
`else
      exp_lat += 1 + lat_row;
`endif
    end
    active = g;
    beats_seen = 0;

    cyc = 0;
    while (!in_ready[g] && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("in_ready_wait", in_ready[g], 1);
    for (int i = 0; i < 64; i++) begin
      in_valid[g] = 1'b1;
      in_data = blk[i];
      @(posedge clk); #1;
    end
    in_valid[g] = stuff;
    in_data = $urandom;
    out_ready[g] = 1'b1;

    lat = 0;
    got = 1'b0;
    for (int c = 0; c < 200 && !got; c++) begin
      @(negedge clk);
      if (c == 1) begin
        check("row_x_first", row_x[g], x0);
        check("busy_run", busy[g], 1);
      end
      if (out_valid[g]) got = 1'b1;
      else lat++;
    end
    check("latency", lat, exp_lat);

    cyc = 0;
    while (beats_seen < 64 && cyc < 400) begin
      @(posedge clk); #1;
      cyc++;
      in_data = $urandom;
      if (abort_at >= 0 && beats_seen == abort_at) break;
      if (toggle) out_ready[g] = ~out_ready[g];
    end
    in_valid[g] = 1'b0;

    if (abort_at >= 0) begin
      active = -1;
      exp_q.delete();
      check("abort_reached", beats_seen, abort_at);
      reset = 1'b0;
      #1;
      check("rst_out_valid", out_valid[g], 0);
      check("rst_out_last", out_last[g], 0);
      check("rst_in_ready", in_ready[g], 0);
      check("rst_busy", busy[g], 0);
      check("rst_row_x", row_x[g], 0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      #1;
      check("rel_in_ready_low", in_ready[g], 0);
      @(posedge clk); #1;
      check("rel_in_ready_high", in_ready[g], 1);
    end else begin
      check("beats", beats_seen, 64);
      check("sb_empty", 32'(exp_q.size()), 0);
      check("in_ready_after", in_ready[g], 1);
      check("busy_after", busy[g], 0);
      active = -1;
    end
    out_ready[g] = 1'b0;
  endtask

  initial begin
    blk_t b;
    in_valid[0] = 1'b0;
    in_valid[1] = 1'b0;
    out_ready[0] = 1'b0;
    out_ready[1] = 1'b0;
    in_data = '0;
    reset = 1'b1;
    #2 reset = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int g = 0; g < 2; g++) begin
      check("reset_in_ready", in_ready[g], 0);
      check("reset_busy", busy[g], 0);
      check("reset_out_valid", out_valid[g], 0);
      check("reset_out_last", out_last[g], 0);
      check("reset_row_x", row_x[g], 0);
    end
    reset = 1'b1;
    #1;
    check("release_in_ready_low", in_ready[0], 0);
    @(posedge clk); #1;
    check("release_in_ready_high", in_ready[0], 1);

    b = '{default: '0}; b[0] = 32'd10;
    run_block(0, b, 1'b0, 1'b0, -1);
    b = '{default: '0}; b[1] = 32'd1;
    run_block(0, b, 1'b0, 1'b0, -1);
    for (int i = 0; i < 64; i++) b[i] = $urandom;
    run_block(0, b, 1'b1, 1'b1, -1);
    for (int i = 0; i < 64; i++) b[i] = $urandom;
    run_block(1, b, 1'b0, 1'b0, -1);
    for (int i = 0; i < 64; i++) b[i] = $urandom;
    run_block(1, b, 1'b1, 1'b1, -1);
    b = '{default: '0}; b[0] = 32'hFFFF_FFF6;
    run_block(1, b, 1'b0, 1'b0, -1);
    for (int i = 0; i < 64; i++) b[i] = $urandom;
    run_block(0, b, 1'b0, 1'b0, 20);
    for (int i = 0; i < 64; i++) b[i] = $urandom;
    run_block(0, b, 1'b0, 1'b0, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rowidct_sched.md
ROWIDCT_SCHED -- requirements
Module: rowidct_sched

Interface
REQ-001 Parameter: ROW_LAT, default 1, cycles from row_x change to valid row_y on the attached row IDCT datapath (range 1..15).
REQ-002 clk  input  1  sole clock; all state changes on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset; one clock, and reset is asynchronous and active-low.
REQ-004 in_valid  input  1  coefficient beat valid.
REQ-005 in_ready  output  1  scheduler accepts a coefficient this cycle.
REQ-006 in_data  input  32  signed coefficient, natural row-major order (index 0..63).
REQ-007 row_x  output  256  packed datapath operands, slot k at bits [32k+31:32k], k=0..7.
REQ-008 row_y  input  256  packed datapath results y0..y7, same packing.
REQ-009 out_valid  output  1  result beat valid.
REQ-010 out_ready  input  1  downstream accepts result beat.
REQ-011 out_data  output  32  signed row-IDCT result, row-major order.
REQ-012 out_last  output  1  high with beat index 63.
REQ-013 busy  output  1  high whenever state is not LOAD, or LOAD with at least one beat accepted.

Function
REQ-014 Storage: one 64 x 32 signed buffer; results written back in place over the row's coefficients.
REQ-015 States: LOAD, ISSUE, WAIT, DRAIN; row counter r (3 bits), beat counter n (6 bits), wait counter w (4 bits).
REQ-016 LOAD: in_ready=1; each in_valid&in_ready writes buffer[n], n increments; on beat 63 go to ISSUE with r=0.
REQ-017 ISSUE: register row_x from row r with slot order x0..x7 = blk[0],blk[4],blk[6],blk[2],blk[1],blk[7],blk[5],blk[3]; go to WAIT, w=0.
REQ-018 row_x held stable from ISSUE until the capture cycle of that row.
REQ-019 WAIT: w increments each cycle; when w==ROW_LAT-1, capture row_y into buffer row r, elements 0..7 = y0..y7; per row cost = 1+ROW_LAT cycles.
REQ-020 After capture: r<7 -> r+1, ISSUE; r==7 -> DRAIN, n=0.
REQ-021 DRAIN: out_valid=1, out_data=buffer[n]; n increments only on out_valid&out_ready; out_data/out_last stable while out_ready=0.
REQ-022 Beat 63 accepted -> LOAD, n=0, same cycle; in_ready rises the following cycle.
REQ-023 in_ready=0 in ISSUE, WAIT, DRAIN; in_valid there is ignored, no buffer write.
REQ-024 out_valid=0 outside DRAIN; out_last=0 except DRAIN with n==63.
REQ-025 No arithmetic in this block; data passed bit-exact, 32-bit signed, no truncation.

Reset
REQ-026 reset low asynchronously forces state LOAD, r=n=w=0, row_x=0, out_valid=0, out_last=0, in_ready=0, busy=0.
REQ-027 in_ready asserts on the first clock edge after reset deasserts.
REQ-028 Reset in any state (including mid-DRAIN) abandons the block; buffer contents not cleared and never emitted.

Configuration
REQ-029 Macro ROWIDCT_SCHED_ZERO_SKIP_EN.
REQ-030 Defined: in ISSUE, if row slots x1..x7 all zero, skip WAIT; write x0<<3 to all 8 elements of row r in that cycle; row cost 1 cycle; row_x still updated.
REQ-031 Undefined: every row goes through ISSUE+WAIT; row cost always 1+ROW_LAT.

Verification
REQ-032 Reset mid-DRAIN at beat 20 -> out_valid=0 immediately, in_ready=1 one cycle after release, next block drains from beat 0.
REQ-033 ROW_LAT=1, block with in_data[0]=10, rest 0, model datapath -> outputs 0..7 = 80, 8..63 = 0, out_last on beat 63 only.
REQ-034 Same block, macro undefined -> 16 cycles from last LOAD beat to first out_valid+1; macro defined -> 8 cycles.
REQ-035 in_data[1]=1 only -> first row_x has slot 4 = 1, all other slots 0 (ordering check).
REQ-036 out_ready toggled 1/0 every cycle in DRAIN -> 64 beats, each value held while low, no loss or duplication; in_valid=1 throughout DRAIN writes nothing.
REQ-037 ROW_LAT=3, random nonzero rows -> capture exactly 3 cycles after ISSUE, block latency 8*4=32 cycles.
